// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the RAM arbiter between the CPU and the UART loader DMA.
package mem_arbiter_pkg;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;
    localparam int   RD_LAT = 2;

    typedef struct packed {
        logic valid;
        logic port;
    } own_t;

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-way round-robin arbiter with a bounded DMA burst lock.
module arb_rr2
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_LOCK = 8
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_cpu_req,
    input  logic i_dma_req,
    input  logic i_dma_lock,
    output logic o_cpu_gnt,
    output logic o_dma_gnt,
    output logic o_winner
);

    localparam int CW = $clog2(MAX_LOCK + 1);

    logic          r_rr_last;
    logic [CW-1:0] r_lock_cnt;
    logic          w_lock_win;
    logic          w_cpu_win;
    logic          w_dma_win;

    always_comb begin
        w_lock_win = i_dma_lock && (r_rr_last == PORT_D)
                     && (r_lock_cnt < CW'(MAX_LOCK));
        w_cpu_win  = 1'b0;
        w_dma_win  = 1'b0;
        if (!i_reset) begin
            if (i_cpu_req && i_dma_req) begin
                if (w_lock_win || (r_rr_last == PORT_C))
                    w_dma_win = 1'b1;
                else
                    w_cpu_win = 1'b1;
            end else if (i_cpu_req) begin
                w_cpu_win = 1'b1;
            end else if (i_dma_req) begin
                w_dma_win = 1'b1;
            end
        end
    end

    assign o_cpu_gnt = w_cpu_win;
    assign o_dma_gnt = w_dma_win;
    assign o_winner  = w_dma_win ? PORT_D : PORT_C;

    // Starting from D lets the CPU win the first tie after reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rr_last  <= PORT_D;
            r_lock_cnt <= '0;
        end else begin
            if (w_cpu_win)
                r_rr_last <= PORT_C;
            else if (w_dma_win)
                r_rr_last <= PORT_D;

            if (w_cpu_win || !i_dma_lock)
                r_lock_cnt <= '0;
            else if (w_dma_win && (r_lock_cnt < CW'(MAX_LOCK)))
                r_lock_cnt <= r_lock_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port system RAM between CPU and DMA, registering the
// winning command and routing read data back to the issuing port.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    input  logic          dma_lock,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    logic          w_cpu_gnt;
    logic          w_dma_gnt;
    logic          w_winner;
    logic          w_gnt;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    logic          r_ram_en;
    logic          r_ram_we;
    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_wdata;
    own_t          r_own [RD_LAT];
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_dma_rdata;
    logic          w_cpu_rvalid;
    logic          w_dma_rvalid;

    arb_rr2 #(
        .MAX_LOCK (MAX_LOCK)
    ) u_arb (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_cpu_req  (cpu_req),
        .i_dma_req  (dma_req),
        .i_dma_lock (dma_lock),
        .o_cpu_gnt  (w_cpu_gnt),
        .o_dma_gnt  (w_dma_gnt),
        .o_winner   (w_winner)
    );

    assign w_gnt       = w_cpu_gnt | w_dma_gnt;
    assign w_sel_we    = (w_winner == PORT_D) ? dma_we    : cpu_we;
    assign w_sel_addr  = (w_winner == PORT_D) ? dma_addr  : cpu_addr;
    assign w_sel_wdata = (w_winner == PORT_D) ? dma_wdata : cpu_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            r_ram_en <= w_gnt;
            if (w_gnt) begin
                r_ram_we    <= w_sel_we;
                r_ram_addr  <= w_sel_addr;
                r_ram_wdata <= w_sel_wdata;
            end else begin
                r_ram_we <= 1'b0;
            end
        end
    end

    // Owner pipeline: entry RD_LAT-1 lines up with ram_rdata.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++)
                r_own[i] <= '0;
        end else begin
            r_own[0].valid <= w_gnt && !w_sel_we;
            r_own[0].port  <= w_winner;
            for (int i = 1; i < RD_LAT; i++)
                r_own[i] <= r_own[i-1];
        end
    end

    assign w_cpu_rvalid = r_own[RD_LAT-1].valid
                          && (r_own[RD_LAT-1].port == PORT_C);
    assign w_dma_rvalid = r_own[RD_LAT-1].valid
                          && (r_own[RD_LAT-1].port == PORT_D);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
        end else begin
            if (w_cpu_rvalid)
                r_cpu_rdata <= ram_rdata;
            if (w_dma_rvalid)
                r_dma_rdata <= ram_rdata;
        end
    end

    assign cpu_gnt    = w_cpu_gnt;
    assign dma_gnt    = w_dma_gnt;
    assign cpu_rvalid = w_cpu_rvalid;
    assign dma_rvalid = w_dma_rvalid;
    assign cpu_rdata  = w_cpu_rvalid ? ram_rdata : r_cpu_rdata;
    assign dma_rdata  = w_dma_rvalid ? ram_rdata : r_dma_rdata;
    assign ram_en     = r_ram_en;
    assign ram_we     = r_ram_we;
    assign ram_addr   = r_ram_addr;
    assign ram_wdata  = r_ram_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port RAM.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr, cpu_wdata;
    logic        cpu_gnt, cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        dma_req, dma_we, dma_lock;
    logic [15:0] dma_addr, dma_wdata;
    logic        dma_gnt, dma_rvalid;
    logic [15:0] dma_rdata;
    logic        ram_en, ram_we;
    logic [15:0] ram_addr, ram_wdata;
    logic [15:0] ram_rdata = 16'h0;
    logic [15:0] mem [0:255];

    int n_assert = 0;
    int n_fail   = 0;

    mem_arbiter #(.AW(16), .DW(16), .MAX_LOCK(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_lock   (dma_lock),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we)
                mem[ram_addr[7:0]] <= ram_wdata;
            else
                ram_rdata <= mem[ram_addr[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        int k;
        bit cdone;
        for (int i = 0; i < 256; i++)
            mem[i] = 16'h0;
        mem[8'h80] = 16'h1234;
        mem[8'h10] = 16'hC010;
        mem[8'h11] = 16'hC011;
        mem[8'h12] = 16'hC012;
        mem[8'h20] = 16'hD020;
        mem[8'h21] = 16'hD021;

        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0; dma_wdata = 16'h0;
        dma_lock = 1'b0;

        // reset holds everything quiet even with both requesting
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("rst_cgnt", cpu_gnt, 0);
            chk("rst_dgnt", dma_gnt, 0);
            chk("rst_ram_en", ram_en, 0);
            chk("rst_crv", cpu_rvalid, 0);
            chk("rst_drv", dma_rvalid, 0);
        end
        cyc();
        reset = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;

        // tie: C, D, C, D with per-port return data
        cyc();
        cpu_req = 1; cpu_addr = 16'h0010; dma_req = 1; dma_addr = 16'h0020;
        smp(); chk("tie0_c", cpu_gnt, 1); chk("tie0_d", dma_gnt, 0);
        cyc(); cpu_addr = 16'h0011;
        smp(); chk("tie1_d", dma_gnt, 1); chk("tie1_c", cpu_gnt, 0);
        cyc(); dma_addr = 16'h0021;
        smp(); chk("tie2_c", cpu_gnt, 1);
        chk("tie2_crv", cpu_rvalid, 1); chk("tie2_cdat", cpu_rdata, 16'hC010);
        chk("tie2_drv", dma_rvalid, 0);
        cyc(); cpu_addr = 16'h0012;
        smp(); chk("tie3_d", dma_gnt, 1); chk("tie3_c", cpu_gnt, 0);
        chk("tie3_drv", dma_rvalid, 1); chk("tie3_ddat", dma_rdata, 16'hD020);
        chk("tie3_crv", cpu_rvalid, 0);
        cyc(); dma_req = 0;
        smp(); chk("tie4_c", cpu_gnt, 1);
        chk("tie4_crv", cpu_rvalid, 1); chk("tie4_cdat", cpu_rdata, 16'hC011);
        chk("tie4_drv", dma_rvalid, 0);
        cyc(); cpu_req = 0;
        smp(); chk("tie5_c", cpu_gnt, 0);
        chk("tie5_drv", dma_rvalid, 1); chk("tie5_ddat", dma_rdata, 16'hD021);
        cyc();
        smp(); chk("tie6_crv", cpu_rvalid, 1); chk("tie6_cdat", cpu_rdata, 16'hC012);
        chk("tie6_dhold", dma_rdata, 16'hD021); chk("tie6_drv", dma_rvalid, 0);
        cyc();
        smp(); chk("tie7_crv", cpu_rvalid, 0);

        // single CPU read
        cyc(); cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0080;
        smp(); chk("rd_cgnt", cpu_gnt, 1); chk("rd_dgnt", dma_gnt, 0);
        cyc(); cpu_req = 0;
        smp(); chk("rd_en", ram_en, 1); chk("rd_addr", ram_addr, 16'h0080);
        chk("rd_we", ram_we, 0); chk("rd_crv1", cpu_rvalid, 0);
        cyc();
        smp(); chk("rd_crv2", cpu_rvalid, 1); chk("rd_cdat", cpu_rdata, 16'h1234);
        chk("rd_drv", dma_rvalid, 0);
        cyc();
        smp(); chk("idle_en", ram_en, 0); chk("idle_addr", ram_addr, 16'h0080);
        chk("idle_crv", cpu_rvalid, 0); chk("idle_chold", cpu_rdata, 16'h1234);

        // DMA burst under lock with a waiting CPU
        k = 0; cdone = 0;
        for (int c = 0; c < 17; c++) begin
            cyc();
            dma_req = 1; dma_we = 1; dma_lock = 1;
            dma_addr = 16'(k); dma_wdata = 16'h5A00 | 16'(k);
            cpu_req = !cdone; cpu_we = 0; cpu_addr = 16'h0080;
            smp();
            chk($sformatf("lock%0d_dgnt", c), dma_gnt, (c != 8));
            chk($sformatf("lock%0d_cgnt", c), cpu_gnt, (c == 8));
            chk($sformatf("lock%0d_crv", c), cpu_rvalid, (c == 10));
            if (dma_gnt) k++;
            if (cpu_gnt) cdone = 1;
        end
        cyc(); dma_req = 0; dma_lock = 0; cpu_req = 0;
        cyc();
        cyc();
        for (int i = 0; i < 16; i++)
            chk($sformatf("mem%0d", i), mem[i], 16'h5A00 | 16'(i));

        // DMA write then CPU read of the same address
        cyc(); dma_req = 1; dma_we = 1; dma_addr = 16'h0002; dma_wdata = 16'h00AA;
        smp(); chk("wr_dgnt", dma_gnt, 1);
        cyc(); dma_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0002;
        smp(); chk("wr_cgnt", cpu_gnt, 1); chk("wr_we", ram_we, 1);
        chk("wr_addr", ram_addr, 16'h0002); chk("wr_wdata", ram_wdata, 16'h00AA);
        cyc(); cpu_req = 0;
        cyc();
        smp(); chk("wr_crv", cpu_rvalid, 1); chk("wr_cdat", cpu_rdata, 16'h00AA);

        // reset between grant and return
        cyc(); cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        smp(); chk("mr_cgnt", cpu_gnt, 1);
        cyc(); cpu_req = 0; reset = 1;
        smp(); chk("mr_en", ram_en, 0); chk("mr_crv0", cpu_rvalid, 0);
        cyc(); reset = 0;
        smp(); chk("mr_crv1", cpu_rvalid, 0); chk("mr_drv1", dma_rvalid, 0);
        cyc();
        smp(); chk("mr_crv2", cpu_rvalid, 0);
        cyc(); cpu_req = 1; cpu_addr = 16'h0011; dma_req = 1; dma_we = 0;
        dma_addr = 16'h0021;
        smp(); chk("mr_tie_c", cpu_gnt, 1); chk("mr_tie_d", dma_gnt, 0);
        cyc(); cpu_req = 0;
        smp(); chk("mr_tie2_d", dma_gnt, 1);
        cyc(); dma_req = 0;
        smp(); chk("mr_crv3", cpu_rvalid, 1); chk("mr_cdat", cpu_rdata, 16'hC011);
        cyc();
        smp(); chk("mr_drv", dma_rvalid, 1); chk("mr_ddat", dma_rdata, 16'hD021);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port system RAM between two requesters: the CPU (port C) and the UART boot-loader DMA (port D).
- Arbitrates every cycle and registers the winning command onto the RAM port.
- Tracks read ownership through the RAM latency and returns read data only to the requester that issued the read.
- Sits between cpu, the uart loader and ram inside computer2.

Parameters:
AW, 16, address width
DW, 16, data width
MAX_LOCK, 8, max consecutive DMA grants under dma_lock before a waiting CPU must be served

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU access request
cpu_we  in  1  1=write, 0=read
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_gnt  out  1  CPU request accepted this cycle (combinational)
cpu_rvalid  out  1  CPU read data valid
cpu_rdata  out  DW  CPU read data
dma_req  in  1  DMA access request
dma_we  in  1  1=write, 0=read
dma_addr  in  AW  DMA address
dma_wdata  in  DW  DMA write data
dma_lock  in  1  DMA requests a burst (keep grant)
dma_gnt  out  1  DMA request accepted this cycle (combinational)
dma_rvalid  out  1  DMA read data valid
dma_rdata  out  DW  DMA read data
ram_en  out  1  RAM command valid (registered)
ram_we  out  1  RAM write enable (registered)
ram_addr  out  AW  RAM address (registered)
ram_wdata  out  DW  RAM write data (registered)
ram_rdata  in  DW  RAM read data, valid 1 cycle after a read command

Behaviour:
- Reset is asynchronous and active-high. It clears:
  - ram_en, ram_we, ram_addr, ram_wdata
  - both rvalid outputs and both rdata outputs
  - lock counter
  - rr_last (reset value = D, so the CPU wins the first tie)
  - the owner pipeline
- Reset asserted mid-operation discards in-flight reads: no rvalid is ever produced for a read accepted before reset.
- Grant, cycle N (combinational):
  - Only one requesting: it wins.
  - Both requesting: the port opposite rr_last wins.
  - Lock override: if dma_lock=1, rr_last=D and lock_cnt<MAX_LOCK, DMA wins.
  - At most one gnt is high per cycle. A gnt is never asserted without its req.
- A requester holds req/we/addr/wdata stable until it sees gnt. Request and gnt high in the same cycle means the request is accepted.
- End of cycle N (registered): if a grant occurred, ram_en=1 and the winner's we/addr/wdata are registered. Otherwise ram_en=0 and ram_we=0.
- rr_last is updated to the winner on every grant.
- lock_cnt:
  - Increments on each DMA grant while dma_lock=1.
  - Saturates at MAX_LOCK.
  - Clears on any CPU grant or when dma_lock=0.
  - Once lock_cnt=MAX_LOCK with cpu_req=1, the next grant goes to the CPU.
- Read return: a read accepted in cycle N issues on the RAM in N+1, and ram_rdata is valid in N+2.
  - The owner's rvalid pulses for one cycle in N+2, with rdata registered from ram_rdata.
  - Total read latency from gnt to rvalid is 2 cycles.
  - Writes produce no rvalid.
- The owner pipeline is 2 stages of {valid, port}. It supports back-to-back reads from alternating ports at one grant per cycle with no bubbles.
- rdata of the non-owner port holds its previous value.
- Simultaneous events:
  - Tie with no lock: alternates C, D, C, D.
  - CPU request arriving during a DMA burst waits until the lock expires or dma_lock drops.
  - A write and a read in consecutive cycles to the same address: the read returns the new data (RAM ordering; no forwarding in the arbiter).
- Idle cycles leave ram_addr and ram_wdata unchanged and hold ram_en=0.

Decomposition:
- Shared package: port-id constants PORT_C=0, PORT_D=1; latency constant RD_LAT=2; owner-pipeline entry struct {valid, port}.
- One sub-module, arb_rr2: 2-way round-robin with lock/starvation counter, producing winner and gnt.
- mem_arbiter contains the command register and owner pipeline.

Test Plan:
- Reset: hold reset=1 with both req=1 -> both gnt=0 (cpu_gnt=dma_gnt=0), ram_en=0 and both rvalid=0 throughout.
- Single read: CPU read addr 0x0080 with RAM holding 0x1234 -> cpu_gnt at N, ram_en/addr=0x0080 at N+1, cpu_rvalid=1 with rdata=0x1234 at N+2, dma_rvalid=0.
- Tie: both read continuously, no lock -> grants C, D, C, D; each rvalid arrives 2 cycles after its own gnt with the correct data per port.
- Lock/starvation: MAX_LOCK=8, dma_lock=1, DMA writes 0x0000..0x000F while cpu_req=1 -> 8 DMA grants, 1 CPU grant, then DMA resumes; memory[0..15] written correctly.
- Reset mid-read: assert reset between gnt and rvalid -> no rvalid pulse. After release, rr_last=D, so the first tie grants the CPU.
- Write-then-read: DMA writes 0x00AA to addr 0x0002, CPU then reads 0x0002 -> cpu_rdata=0x00AA.
